dpu_run_monitor: RTL and testbench

Parametrised run monitor for the DPU bench and the DPU top. It tracks the start/done handshakes of up to P_NUM_ENG engines (CONV, POOL, LINEAR, MOVER, ...) and measures each run's cycle count. It flags timeouts and protocol errors, and produces one aggregate `all_done` and one interrupt. It replaces the single fixed `done` wait on one tester with a mask-selectable, multi-engine completion and watchdog function.

---
 rtl/dpu_run_monitor_pkg.sv | 14 +
 rtl/dpu_run_monitor_chan.sv | 77 +++++++
 rtl/dpu_run_monitor.sv | 74 +++++++
 tb/tb_dpu_run_monitor.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/dpu_run_monitor_pkg.sv
// Shared types and default sizing for the DPU run monitor.
package dpu_run_monitor_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2,
        TMO  = 2'd3
    } mon_state_e;

    localparam int DEF_NUM_ENG   = 4;
    localparam int DEF_CNT_WIDTH = 32;

endpackage

// File: rtl/dpu_run_monitor_chan.sv
// One engine's run tracker: state machine, saturating cycle counter, watchdog,
// sticky protocol-error flag and pending-completion flag.
module dpu_run_monitor_chan
    import dpu_run_monitor_pkg::*;
#(
    parameter int P_CNT_WIDTH = DEF_CNT_WIDTH
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   start_i,
    input  logic                   done_i,
    input  logic                   clear_i,
    input  logic [P_CNT_WIDTH-1:0] timeout_i,
    output mon_state_e             state_o,
    output logic [P_CNT_WIDTH-1:0] cnt_o,
    output logic                   err_o,
    output logic                   pend_o
);

    mon_state_e             state_q;
    logic [P_CNT_WIDTH-1:0] cnt_q;
    logic                   err_q;
    logic                   pend_q;

    // Compare on the unsaturated value so a saturated counter can never match.
    logic [P_CNT_WIDTH:0]   cnt_inc;
    logic [P_CNT_WIDTH-1:0] cnt_sat;
    logic                   tmo_hit;

    assign cnt_inc = {1'b0, cnt_q} + (P_CNT_WIDTH+1)'(1);
    assign cnt_sat = cnt_inc[P_CNT_WIDTH] ? cnt_q : cnt_inc[P_CNT_WIDTH-1:0];
    assign tmo_hit = (timeout_i != '0) && (cnt_inc == {1'b0, timeout_i});

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            pend_q  <= 1'b0;
        end else if (clear_i) begin
            state_q <= IDLE;
            err_q   <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            case (state_q)
                RUN: begin
                    if (start_i) err_q <= 1'b1;
                    if (done_i) begin
                        state_q <= DONE;
                        pend_q  <= 1'b1;
                        cnt_q   <= cnt_sat;
                    end else if (tmo_hit) begin
                        state_q <= TMO;
                        pend_q  <= 1'b1;
                        cnt_q   <= timeout_i;
                    end else begin
                        cnt_q   <= cnt_sat;
                    end
                end
                default: begin
                    // IDLE, DONE and TMO: done is a protocol error, start begins a new run.
                    if (done_i) err_q <= 1'b1;
                    if (start_i) begin
                        state_q <= RUN;
                        cnt_q   <= '0;
                    end
                end
            endcase
        end
    end

    assign state_o = state_q;
    assign cnt_o   = cnt_q;
    assign err_o   = err_q;
    assign pend_o  = pend_q;

endmodule

// File: rtl/dpu_run_monitor.sv
// Multi-engine run monitor: per-engine trackers plus completion aggregation,
// level interrupt and a registered cycle-count readout.
module dpu_run_monitor
    import dpu_run_monitor_pkg::*;
#(
    parameter int  P_NUM_ENG   = DEF_NUM_ENG,
    parameter int  P_CNT_WIDTH = DEF_CNT_WIDTH,
    localparam int SEL_W       = (P_NUM_ENG > 1) ? $clog2(P_NUM_ENG) : 1
) (
    input  logic                   ACLK,
    input  logic                   ARESET,
    input  logic [P_NUM_ENG-1:0]   start_i,
    input  logic [P_NUM_ENG-1:0]   done_i,
    input  logic [P_NUM_ENG-1:0]   eng_en_i,
    input  logic [P_NUM_ENG-1:0]   irq_en_i,
    input  logic [P_NUM_ENG-1:0]   clear_i,
    input  logic [P_CNT_WIDTH-1:0] timeout_i,
    input  logic [SEL_W-1:0]       rd_sel_i,
    output logic [P_CNT_WIDTH-1:0] rd_cnt_o,
    output logic [P_NUM_ENG-1:0]   busy_o,
    output logic [P_NUM_ENG-1:0]   tmo_o,
    output logic [P_NUM_ENG-1:0]   err_o,
    output logic                   all_done_o,
    output logic                   irq_o
);

    mon_state_e                            st [P_NUM_ENG];
    logic [P_NUM_ENG-1:0][P_CNT_WIDTH-1:0] cnt;
    logic [P_NUM_ENG-1:0]                  pend;
    logic [P_NUM_ENG-1:0]                  fin;

    for (genvar g = 0; g < P_NUM_ENG; g++) begin : g_ch
        dpu_run_monitor_chan #(
            .P_CNT_WIDTH(P_CNT_WIDTH)
        ) u_ch (
            .clk_i    (ACLK),
            .rst_i    (ARESET),
            .start_i  (start_i[g]),
            .done_i   (done_i[g]),
            .clear_i  (clear_i[g]),
            .timeout_i(timeout_i),
            .state_o  (st[g]),
            .cnt_o    (cnt[g]),
            .err_o    (err_o[g]),
            .pend_o   (pend[g])
        );

        assign busy_o[g] = (st[g] == RUN);
        assign tmo_o[g]  = (st[g] == TMO);
        assign fin[g]    = (st[g] == DONE) || (st[g] == TMO);
    end

    assign all_done_o = (eng_en_i != '0) && (&(fin | ~eng_en_i));
    assign irq_o      = |(pend & irq_en_i);

    // Indices with no engine behind them read back as zero.
    logic [P_CNT_WIDTH-1:0] rd_cnt_d;
    logic [P_CNT_WIDTH-1:0] rd_cnt_q;

    always_comb begin
        rd_cnt_d = '0;
        for (int i = 0; i < P_NUM_ENG; i++) begin
            if (rd_sel_i == SEL_W'(i)) rd_cnt_d = cnt[i];
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) rd_cnt_q <= '0;
        else        rd_cnt_q <= rd_cnt_d;
    end

    assign rd_cnt_o = rd_cnt_q;

endmodule

// File: tb/tb_dpu_run_monitor.sv
// Directed bench: a 4-engine/32-bit instance and a 3-engine/4-bit instance
// (saturation, out-of-range readout, reset mid-run), scoreboard-checked.
module tb_dpu_run_monitor;

    logic ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    // instance A: 4 engines, 32-bit counters
    logic        a_rst;
    logic [3:0]  a_start, a_done, a_en, a_irq_en, a_clear;
    logic [31:0] a_timeout;
    logic [1:0]  a_sel;
    logic [31:0] a_rd;
    logic [3:0]  a_busy, a_tmo, a_err;
    logic        a_all, a_irq;

    // instance B: 3 engines, 4-bit counters
    logic        b_rst;
    logic [2:0]  b_start, b_done, b_en, b_irq_en, b_clear;
    logic [3:0]  b_timeout;
    logic [1:0]  b_sel;
    logic [3:0]  b_rd;
    logic [2:0]  b_busy, b_tmo, b_err;
    logic        b_all, b_irq;

    dpu_run_monitor #(.P_NUM_ENG(4), .P_CNT_WIDTH(32)) u_a (
        .ACLK(ACLK), .ARESET(a_rst), .start_i(a_start), .done_i(a_done),
        .eng_en_i(a_en), .irq_en_i(a_irq_en), .clear_i(a_clear),
        .timeout_i(a_timeout), .rd_sel_i(a_sel), .rd_cnt_o(a_rd),
        .busy_o(a_busy), .tmo_o(a_tmo), .err_o(a_err),
        .all_done_o(a_all), .irq_o(a_irq)
    );

    dpu_run_monitor #(.P_NUM_ENG(3), .P_CNT_WIDTH(4)) u_b (
        .ACLK(ACLK), .ARESET(b_rst), .start_i(b_start), .done_i(b_done),
        .eng_en_i(b_en), .irq_en_i(b_irq_en), .clear_i(b_clear),
        .timeout_i(b_timeout), .rd_sel_i(b_sel), .rd_cnt_o(b_rd),
        .busy_o(b_busy), .tmo_o(b_tmo), .err_o(b_err),
        .all_done_o(b_all), .irq_o(b_irq)
    );

    int total = 0;
    int bad   = 0;
    string       tag_q[$];
    logic [31:0] exp_q[$];

    task automatic tick(input int n = 1);
        repeat (n) @(posedge ACLK);
        #1;
    endtask

    task automatic expect_v(input string tag, input logic [31:0] v);
        tag_q.push_back(tag);
        exp_q.push_back(v);
    endtask

    task automatic check(input logic [31:0] obs);
        string       t;
        logic [31:0] e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $error("FAIL scoreboard_empty observed=%0h", obs);
            return;
        end
        t = tag_q.pop_front();
        e = exp_q.pop_front();
        assert (obs === e) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", t, obs, e);
        end
    endtask

    initial begin
        a_rst = 1'b1; a_start = '0; a_done = '0; a_en = '0; a_irq_en = '0;
        a_clear = '0; a_timeout = '0; a_sel = '0;
        b_rst = 1'b1; b_start = '0; b_done = '0; b_en = '0; b_irq_en = '0;
        b_clear = '0; b_timeout = '0; b_sel = '0;
        tick(3);

        // reset state
        expect_v("reset_flags", 32'h0);
        check(32'({a_busy, a_tmo, a_err, a_all, a_irq}));
        expect_v("reset_rd", 32'h0);
        check(a_rd);
        a_rst = 1'b0; b_rst = 1'b0;
        tick(2);

        // basic run on engine 0: 20 cycles start->done
        a_en = 4'b0001; a_irq_en = 4'b0001; a_sel = 2'd0;
        a_start = 4'b0001;
        expect_v("basic_busy_start", 32'h1);
        tick(); a_start = '0;
        check(32'(a_busy[0]));
        tick(19);
        expect_v("basic_busy_irq_mid", 32'h2);
        check(32'({a_busy[0], a_irq}));
        a_done = 4'b0001;
        expect_v("basic_done_busy_irq_all", 32'h3);
        tick(); a_done = '0;
        check(32'({a_busy[0], a_irq, a_all}));
        expect_v("basic_cnt", 32'd20);
        tick();
        check(a_rd);

        // watchdog on engine 1
        a_timeout = 32'd8; a_sel = 2'd1;
        a_start = 4'b0010;
        tick(); a_start = '0;
        tick(7);
        expect_v("wd_pre_tmo", 32'h2);
        check(32'({a_busy[1], a_tmo[1]}));
        expect_v("wd_tmo", 32'h1);
        tick();
        check(32'({a_busy[1], a_tmo[1]}));
        expect_v("wd_cnt", 32'd8);
        tick();
        check(a_rd);

        // done coincident with the timeout: DONE wins
        a_start = 4'b0010;
        tick(); a_start = '0;
        tick(7);
        a_done = 4'b0010;
        expect_v("wd_done_wins", 32'h0);
        tick(); a_done = '0;
        check(32'({a_busy[1], a_tmo[1]}));
        expect_v("wd_done_cnt", 32'd8);
        tick();
        check(a_rd);

        // aggregate over engines 0/1/3
        a_clear = 4'b1111;
        expect_v("agg_cleared", 32'h0);
        tick(); a_clear = '0;
        check(32'({a_busy, a_err, a_all, a_irq}));
        a_en = 4'b1011; a_timeout = '0;
        a_start = 4'b1111;
        expect_v("agg_busy", 32'hF);
        tick(); a_start = '0;
        check(32'(a_busy));
        a_done = 4'b0001;
        expect_v("agg_after_e0", 32'h0);
        tick(); a_done = '0;
        check(32'(a_all));
        tick(2);
        a_done = 4'b1000;
        expect_v("agg_after_e3", 32'h0);
        tick(); a_done = '0;
        check(32'(a_all));
        a_done = 4'b0010;
        expect_v("agg_after_e1", 32'h1);
        tick(); a_done = '0;
        check(32'(a_all));
        a_en = 4'b0000;
        expect_v("agg_en_zero", 32'h0);
        tick();
        check(32'(a_all));

        // protocol errors on engine 2
        a_clear = 4'b0100;
        tick(); a_clear = '0;
        a_done = 4'b0100;
        expect_v("err_done_idle", 32'h1);
        tick(); a_done = '0;
        check(32'(a_err[2]));
        a_clear = 4'b0100;
        expect_v("err_cleared", 32'h0);
        tick(); a_clear = '0;
        check(32'(a_err[2]));
        a_start = 4'b0100;
        tick(); a_start = '0;
        tick(3);
        a_start = 4'b0100;
        expect_v("err_restart_in_run", 32'h3);
        tick(); a_start = '0;
        check(32'({a_busy[2], a_err[2]}));
        tick(2);
        a_sel = 2'd2;
        expect_v("err_cnt_continues", 32'd6);
        tick();
        check(a_rd);
        a_clear = 4'b0100; a_start = 4'b0100;
        expect_v("clear_beats_start", 32'h0);
        tick(); a_clear = '0; a_start = '0;
        check(32'({a_busy[2], a_err[2]}));
        expect_v("start_dropped", 32'h0);
        tick();
        check(32'(a_busy[2]));

        // readout sweep on A
        a_sel = 2'd0; expect_v("rd_e0", 32'd1); tick(); check(a_rd);
        a_sel = 2'd1; expect_v("rd_e1", 32'd5); tick(); check(a_rd);
        a_sel = 2'd2; expect_v("rd_e2", 32'd7); tick(); check(a_rd);
        a_sel = 2'd3; expect_v("rd_e3", 32'd4); tick(); check(a_rd);

        // saturation on B: engine 0 runs 20 cycles, engine 1 finishes at 5
        b_en = 3'b001; b_irq_en = 3'b011;
        b_start = 3'b011;
        tick(); b_start = '0;
        tick(4);
        b_done = 3'b010;
        tick(); b_done = '0;
        tick(15);
        expect_v("sat_busy_irq", 32'h3);
        check(32'({b_busy[0], b_irq}));
        b_sel = 2'd0; expect_v("sat_cnt", 32'd15); tick(); check(32'(b_rd));
        b_sel = 2'd1; expect_v("b_rd_e1", 32'd5);  tick(); check(32'(b_rd));
        b_sel = 2'd2; expect_v("b_rd_e2", 32'd0);  tick(); check(32'(b_rd));
        b_sel = 2'd3; expect_v("b_rd_oob", 32'd0); tick(); check(32'(b_rd));
        b_sel = 2'd0; expect_v("sat_hold", 32'd15); tick(); check(32'(b_rd));

        // reset mid-run, with a start presented on the reset edge
        b_rst = 1'b1; b_start = 3'b100;
        expect_v("rst_flags", 32'h0);
        tick(); b_rst = 1'b0; b_start = '0;
        check(32'({b_busy, b_tmo, b_err, b_all, b_irq}));
        expect_v("rst_rd", 32'h0);
        check(32'(b_rd));
        expect_v("rst_start_ignored", 32'h0);
        tick();
        check(32'(b_busy));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
